// File: rtl/video_tpg_pkg.sv
// Shared types for the video test-pattern generator: pattern modes
// and the colour-bar table.
package video_tpg_pkg;

    typedef enum logic [1:0] {
        BARS    = 2'd0,
        CHECKER = 2'd1,
        RAMP    = 2'd2,
        SOLID   = 2'd3
    } tpg_mode_e;

    localparam int NUM_BARS = 8;

    // {R,G,B} on/off per bar, bar 0 (white) in the MSBs
    localparam logic [23:0] BAR_TBL =
        24'b111_110_011_010_101_100_001_000;

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        int sh;
        sh = 3 * (7 - int'(idx));
        return BAR_TBL[sh +: 3];
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters with active/sync/frame decode; counters are held
// at the origin while i_run is low.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_run,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_sof,
    output logic          o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v == VW'(V_TOTAL - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (!i_run) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    assign o_h_cnt     = r_h;
    assign o_v_cnt     = r_v;
    assign o_active    = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
    assign o_hs        = (int'(r_h) >= H_ACTIVE + H_FP) &&
                         (int'(r_h) <  H_ACTIVE + H_FP + H_SYNC);
    assign o_vs        = (int'(r_v) >= V_ACTIVE + V_FP) &&
                         (int'(r_v) <  V_ACTIVE + V_FP + V_SYNC);
    assign o_sof       = (r_h == '0) && (r_v == '0);
    assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/video_tpg.sv
// Video test-pattern generator: bars, checker, ramp, solid colour.
// Optional perimeter border enabled by defining TPG_BORDER_EN.
module video_tpg
    import video_tpg_pkg::*;
#(
    parameter int COLOR_W    = 8,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 run,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [3*COLOR_W-1:0] vid_data,
    output logic                 vid_de,
    output logic                 vid_hsync,
    output logic                 vid_vsync,
    output logic                 vid_sof
);

    localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int RGB_W = 3 * COLOR_W;

    logic [HW-1:0]    w_h;
    logic [VW-1:0]    w_v;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic             w_sof;
    logic             w_frame_end;
    logic [2:0]       w_bar_idx;
    logic [2:0]       w_bar;
    logic             w_chk;
    logic [COLOR_W-1:0] w_ramp;
    logic [RGB_W-1:0] w_pix;

    tpg_mode_e        r_mode;
    logic [RGB_W-1:0] r_solid;
    logic [RGB_W-1:0] r_data;
    logic             r_de;
    logic             r_hs;
    logic             r_vs;
    logic             r_sof;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .i_clk       (CLK),
        .i_rst_n     (RSTn),
        .i_run       (run),
        .o_h_cnt     (w_h),
        .o_v_cnt     (w_v),
        .o_active    (w_active),
        .o_hs        (w_hs),
        .o_vs        (w_vs),
        .o_sof       (w_sof),
        .o_frame_end (w_frame_end)
    );

    assign w_bar_idx = 3'(w_h / HW'(BAR_W));
    assign w_bar     = bar_rgb(w_bar_idx);
    assign w_chk     = (((w_h >> CHECK_LOG2) & HW'(1)) != '0) ^
                       (((w_v >> CHECK_LOG2) & VW'(1)) != '0);
    assign w_ramp    = COLOR_W'(w_h);

    always_comb begin
        w_pix = '0;
        unique case (r_mode)
            BARS:    w_pix = {{COLOR_W{w_bar[2]}},
                              {COLOR_W{w_bar[1]}},
                              {COLOR_W{w_bar[0]}}};
            CHECKER: w_pix = w_chk ? '0 : '1;
            RAMP:    w_pix = {3{w_ramp}};
            SOLID:   w_pix = r_solid;
        endcase
`ifdef TPG_BORDER_EN
        if (w_h == '0 || w_h == HW'(H_ACTIVE - 1) ||
            w_v == '0 || w_v == VW'(V_ACTIVE - 1))
            w_pix = '1;
`endif
    end

    // Pattern settings only change across a frame boundary or while idle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_mode  <= BARS;
            r_solid <= '0;
            r_data  <= '0;
            r_de    <= 1'b0;
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_sof   <= 1'b0;
        end else begin
            if (!run || w_frame_end) begin
                r_mode  <= tpg_mode_e'(mode);
                r_solid <= solid_rgb;
            end
            r_de   <= run && w_active;
            r_data <= (run && w_active) ? w_pix : '0;
            r_hs   <= (run && w_hs) ? HS_POL : ~HS_POL;
            r_vs   <= (run && w_vs) ? VS_POL : ~VS_POL;
            r_sof  <= run && w_sof;
        end
    end

    assign vid_data  = r_data;
    assign vid_de    = r_de;
    assign vid_hsync = r_hs;
    assign vid_vsync = r_vs;
    assign vid_sof   = r_sof;

endmodule

// File: tb/tb_video_tpg.sv
// Self-checking bench for video_tpg: two instances (sync polarity 1
// and 0) compared against a raster-level reference model.
module tb_video_tpg;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSY = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSY = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        run = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_rgb = 24'h0;

    logic [23:0] vid_data, d0;
    logic        vid_de, vid_hsync, vid_vsync, vid_sof;
    logic        de0, hs0, vs0, sof0;

    int total = 0;
    int bad = 0;

    int          mh, mv, mmode;
    logic [23:0] msolid;
    logic [23:0] e_data;
    logic        e_de, e_hs, e_vs, e_sof;
    logic [55:0] expv;
    logic [55:0] obs;
    logic [55:0] rstv;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                             24'h00FF00, 24'hFF00FF, 24'hFF0000,
                             24'h0000FF, 24'h000000};

    assign obs = {vid_data, vid_de, vid_hsync, vid_vsync, vid_sof,
                  d0, de0, hs0, vs0, sof0};

    always #5 CLK = ~CLK;

    video_tpg #(
        .COLOR_W(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CHECK_LOG2(1)
    ) u_dut (
        .CLK(CLK), .RSTn(RSTn), .run(run), .mode(mode),
        .solid_rgb(solid_rgb), .vid_data(vid_data), .vid_de(vid_de),
        .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_sof(vid_sof)
    );

    video_tpg #(
        .COLOR_W(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(1)
    ) u_dut0 (
        .CLK(CLK), .RSTn(RSTn), .run(run), .mode(mode),
        .solid_rgb(solid_rgb), .vid_data(d0), .vid_de(de0),
        .vid_hsync(hs0), .vid_vsync(vs0), .vid_sof(sof0)
    );

    function automatic logic [23:0] pix(int h, int v, int md,
                                        logic [23:0] s);
        logic [23:0] p;
        case (md)
            0:       p = bars[h / (HA / 8)];
            1:       p = ((((h >> 1) ^ (v >> 1)) & 1) == 0) ?
                         24'hFFFFFF : 24'h0;
            2:       p = {3{8'(h % 256)}};
            default: p = s;
        endcase
`ifdef TPG_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)
            p = 24'hFFFFFF;
`endif
        return p;
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        mmode = 0;
        msolid = 24'h0;
    endtask

    // Predict the outputs produced by the coming edge, then take it.
    task automatic tick();
        logic act;
        act    = run && mh < HA && mv < VA;
        e_de   = act;
        e_data = act ? pix(mh, mv, mmode, msolid) : 24'h0;
        e_hs   = run && mh >= HA + HFP && mh < HA + HFP + HSY;
        e_vs   = run && mv >= VA + VFP && mv < VA + VFP + VSY;
        e_sof  = run && mh == 0 && mv == 0;
        expv   = {e_data, e_de, e_hs, e_vs, e_sof,
                  e_data, e_de, ~e_hs, ~e_vs, e_sof};
        if (!run) begin
            mmode = int'(mode);
            msolid = solid_rgb;
            mh = 0;
            mv = 0;
        end else begin
            if (mh == HT - 1 && mv == VT - 1) begin
                mmode = int'(mode);
                msolid = solid_rgb;
            end
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        rstv = {24'h0, 4'b0000, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        RSTn = 1'b0;
        run = 1'b1;
        mode = 2'd2;
        solid_rgb = 24'hABCDEF;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            total++;
            if (obs !== rstv) begin
                bad++;
                $display("FAIL reset got=%h req=%h", obs, rstv);
            end
        end
    endtask

    task automatic test_bars();
        mode = 2'd0;
        solid_rgb = 24'h0;
        run = 1'b1;
        RSTn = 1'b1;
        model_reset();
        for (int i = 0; i < HT; i++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL bars_model i=%0d got=%h req=%h", i, obs, expv);
            end
            total++;
            if (vid_data !== ((i < 8) ? bars[i] : 24'h0) ||
                vid_sof !== (i == 0)) begin
                bad++;
                $display("FAIL bars_line0 i=%0d got=%h/%b", i,
                         vid_data, vid_sof);
            end
        end
    endtask

    task automatic test_freerun();
        int c, fall_c, n_de, n_hs, n_vs;
        logic p_de, p_hs;
        for (int k = 0; k < HT * VT && !(mh == 0 && mv == 0); k++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL align got=%h req=%h", obs, expv);
            end
        end
        c = 0;
        fall_c = -100;
        p_de = vid_de;
        p_hs = vid_hsync;
        for (int f = 0; f < 2; f++) begin
            n_de = 0;
            n_hs = 0;
            n_vs = 0;
            for (int k = 0; k < HT * VT; k++) begin
                mode = 2'($urandom_range(0, 3));
                solid_rgb = 24'($urandom);
                tick();
                c++;
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL freerun f=%0d k=%0d got=%h req=%h",
                             f, k, obs, expv);
                end
                n_de += int'(vid_de);
                n_hs += int'(vid_hsync);
                n_vs += int'(vid_vsync);
                if (p_de && !vid_de) fall_c = c;
                if (!p_hs && vid_hsync && fall_c >= 0) begin
                    total++;
                    if (c - fall_c != 2) begin
                        bad++;
                        $display("FAIL hs_gap got=%0d req=2", c - fall_c);
                    end
                    fall_c = -100;
                end
                p_de = vid_de;
                p_hs = vid_hsync;
            end
            total++;
            if (n_de != 32 || n_hs != 14 || n_vs != 14) begin
                bad++;
                $display("FAIL frame_counts de=%0d hs=%0d vs=%0d req=32/14/14",
                         n_de, n_hs, n_vs);
            end
        end
    endtask

    task automatic test_mode_change();
        int ph;
        run = 1'b0;
        mode = 2'd0;
        tick();
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL mc_idle got=%h req=%h", obs, expv);
        end
        run = 1'b1;
        for (int k = 0; k < HT * VT; k++) begin
            if (k == 2 * HT + 3) mode = 2'd2;
            ph = mh;
            tick();
            total++;
            if (obs !== expv || (e_de && vid_data !== pix(ph, 1, 0, 0) &&
                                 ph != 0)) begin
                bad++;
                $display("FAIL mc_bars k=%0d got=%h req=%h", k, obs, expv);
            end
        end
        for (int i = 0; i < HA; i++) begin
            tick();
            total++;
            if (vid_data !== ({3{8'(i)}} | ((i == 0 || i == HA - 1 ||
                               mv == 0) ? pix(i, 0, 2, 0) : 24'h0)) ||
                obs !== expv) begin
                bad++;
                $display("FAIL mc_ramp i=%0d got=%h", i, vid_data);
            end
        end
    endtask

    task automatic test_run_drop();
        for (int k = 0; k < 2 * HT * VT && !(mh == 3 && mv == 2); k++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL rd_pre got=%h req=%h", obs, expv);
            end
        end
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs !== expv || vid_de !== 1'b0 || vid_data !== 24'h0 ||
                vid_hsync !== 1'b0 || hs0 !== 1'b1 || vid_vsync !== 1'b0) begin
                bad++;
                $display("FAIL rd_blank i=%0d got=%h req=%h", i, obs, expv);
            end
        end
        run = 1'b1;
        tick();
        total++;
        if (obs !== expv || vid_sof !== 1'b1 || vid_de !== 1'b1) begin
            bad++;
            $display("FAIL rd_resume got=%h req=%h", obs, expv);
        end
    endtask

    task automatic test_solid();
        int ph, pv;
        logic [23:0] want;
        run = 1'b0;
        mode = 2'd3;
        solid_rgb = 24'h123456;
        tick();
        run = 1'b1;
        for (int k = 0; k < HT * VT; k++) begin
            ph = mh;
            pv = mv;
            tick();
            if (k == 0) begin
                mode = 2'd1;
                solid_rgb = 24'h999999;
            end
            want = 24'h123456;
`ifdef TPG_BORDER_EN
            if (ph == 0 || ph == HA - 1 || pv == 0 || pv == VA - 1)
                want = 24'hFFFFFF;
`endif
            total++;
            if (obs !== expv || (e_de && vid_data !== want)) begin
                bad++;
                $display("FAIL solid k=%0d got=%h req=%h", k, vid_data, want);
            end
        end
    endtask

    task automatic test_async_reset();
        rstv = {24'h0, 4'b0000, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 2 * HT * VT && !(mh == 11 && mv == 1); k++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL ar_pre got=%h req=%h", obs, expv);
            end
        end
        total++;
        if (hs0 !== 1'b0) begin
            bad++;
            $display("FAIL ar_hs_active got=%b req=0", hs0);
        end
        #2;
        RSTn = 1'b0;
        #1;
        total++;
        if (obs !== rstv) begin
            bad++;
            $display("FAIL ar_immediate got=%h req=%h", obs, rstv);
        end
        model_reset();
        @(posedge CLK);
        #1;
        total++;
        if (obs !== rstv) begin
            bad++;
            $display("FAIL ar_held got=%h req=%h", obs, rstv);
        end
        mode = 2'd1;
        run = 1'b1;
        RSTn = 1'b1;
        for (int i = 0; i < 2 * HT; i++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL ar_after i=%0d got=%h req=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            run = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) solid_rgb = 24'($urandom);
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random k=%0d got=%h req=%h", k, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_freerun();
        test_mode_change();
        test_run_drop();
        test_solid();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/video_tpg.md
VIDEO_TPG -- requirements
Module: video_tpg

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
- COLOR_W, 8, bits per colour component.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 1280 / 110 / 40 / 220, horizontal timing in pixels.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 720 / 5 / 5 / 20, vertical timing in lines.
- HS_POL / VS_POL, 1 / 1, sync active level.
- CHECK_LOG2, 5, log2 of checker square size.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
- CLK, in, 1, pixel clock.
- RSTn, in, 1, reset.
- run, in, 1, timing enable.
- mode, in, 2, pattern select.
- solid_rgb, in, 3*COLOR_W, solid colour.
- vid_data, out, 3*COLOR_W, {R,G,B}, with R in the MSBs.
- vid_de, out, 1, active video.
- vid_hsync, out, 1, horizontal sync.
- vid_vsync, out, 1, vertical sync.
- vid_sof, out, 1, start-of-frame pulse.
REQ-003 The block SHALL use one clock, CLK; reset is asynchronous and active-low on RSTn.

Function
REQ-004 h_cnt SHALL count 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; v_cnt SHALL count 0..V_TOTAL-1, incrementing when h_cnt wraps and wrapping to 0 after V_TOTAL-1.
REQ-005 Active video SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-006 hsync SHALL be active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync SHALL be active for the whole lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
REQ-007 All outputs SHALL be registered with exactly 1 cycle latency from the counter state; data, de, hsync, vsync and sof SHALL be mutually aligned.
REQ-008 When sync is inactive, vid_hsync SHALL output ~HS_POL and vid_vsync SHALL output ~VS_POL.
REQ-009 vid_data SHALL be 0 whenever de is low.
REQ-010 vid_sof SHALL be a 1-cycle pulse aligned with pixel (0,0).
REQ-011 mode 0 (BARS) SHALL output 8 bars of width H_ACTIVE/8, left to right: white, yellow, cyan, green, magenta, red, blue, black; each component is all-ones or 0. H_ACTIVE SHALL be a multiple of 8.
REQ-012 mode 1 (CHECKER) SHALL output white when ((h_cnt>>CHECK_LOG2) ^ (v_cnt>>CHECK_LOG2)) bit 0 is 0, else black.
REQ-013 mode 2 (RAMP) SHALL set all components to h_cnt[COLOR_W-1:0]; the value wraps modulo 2^COLOR_W.
REQ-014 mode 3 (SOLID) SHALL output the latched solid_rgb.
REQ-015 mode and solid_rgb SHALL be latched only in the last cycle of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) and while run is low; a mid-frame change SHALL NOT affect the current frame.
REQ-016 When run is low, the counters SHALL be held at 0, outputs SHALL be blank with syncs inactive, and sof SHALL be low.
REQ-017 When run rises, pixel (0,0) SHALL appear on the outputs 1 cycle later with sof=1.
REQ-018 When run is deasserted mid-frame, the block SHALL blank on the next cycle; there is no partial-frame resume.

Reset
REQ-019 While RSTn=0, the block SHALL set h_cnt=v_cnt=0, latched mode=0, latched solid=0, vid_data=0, vid_de=0, vid_sof=0, vid_hsync=~HS_POL and vid_vsync=~VS_POL.
REQ-020 After RSTn releases with run=1, the first output cycle SHALL be pixel (0,0) with sof=1.
REQ-021 Reset asserted mid-frame SHALL force the reset values immediately, without waiting for a clock edge.

Configuration
REQ-022 With TPG_BORDER_EN defined, active pixels with h_cnt=0, h_cnt=H_ACTIVE-1, v_cnt=0 or v_cnt=V_ACTIVE-1 SHALL be forced to all-ones in every mode.
REQ-023 Without TPG_BORDER_EN, no border logic SHALL be present and the patterns SHALL be exactly as in REQ-011..REQ-014.

Structure
REQ-024 Package video_tpg_pkg SHALL hold the mode enum (BARS, CHECKER, RAMP, SOLID) and the 8-entry bar colour table.
REQ-025 Sub-module video_timing_gen SHALL contain the counters and the sync/active decode.
REQ-026 video_tpg SHALL contain the pattern mux and the output registers.

Verification
Bench parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), COLOR_W=8, CHECK_LOG2=1.
REQ-027 Reset release with run=1 and mode=0 -> line 0 data FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000, then 0; sof high only on the first pixel.
REQ-028 Free-run for 2 frames -> 32 de cycles per 98-cycle frame; hsync high for 2 cycles beginning 2 cycles after de falls; vsync high for exactly line 5 (14 cycles).
REQ-029 mode changed 0->2 mid-frame -> bars persist to the end of the frame; the next frame outputs ramp 000000, 010101, ... 070707.
REQ-030 run dropped at h=3,v=2 and re-raised 5 cycles later -> blank with syncs inactive in between; pixel (0,0) with sof=1 one cycle after the rise.
REQ-031 mode=3 with solid_rgb=123456 latched -> every active pixel is 123456; with TPG_BORDER_EN defined, the perimeter pixels are FFFFFF.
REQ-032 RSTn pulsed low mid-line with HS_POL=0 -> outputs go to the reset values immediately, with hsync=1.
